kypd_matrix_scanner: RTL

//  Parametrised scanner for an N_ROWS x N_COLS matrix keypad (Pmod KYPD = 4x4).

---
 rtl/kypd_matrix_scanner_if.sv | 21 ++
 rtl/kypd_matrix_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/kypd_matrix_scanner_if.sv
// Event port between the keypad scanner and its consumer.
// The scanner drives the event fields and valid; the consumer drives ready.
interface kypd_matrix_scanner_if #(
  parameter int KEY_W = 4
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_code;
  logic             evt_press;
  logic             evt_repeat;

  modport master (
    output evt_valid, evt_code, evt_press, evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_press, evt_repeat,
    output evt_ready
  );
endinterface

// File: rtl/kypd_matrix_scanner.sv
// Matrix keypad scanner with frame-level debounce, press/release events and multi-key flag.
// Define KPD_REPEAT_EN to add auto-repeat press events while a single key stays held.
module kypd_matrix_scanner #(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int COL_DWELL       = 100_000,
  parameter int SETTLE          = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 125,
  parameter int REPEAT_RATE     = 25
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic [N_ROWS-1:0]     row_i,
  output logic [N_COLS-1:0]     col_o,
  kypd_matrix_scanner_if.master evt_if,
  output logic                  key_held_o,
  output logic                  multi_key_o
);
  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int KEY_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int DW     = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
  localparam int CW     = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int SW     = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_e;

  logic              active_q;
  logic [CW-1:0]     col_idx_q;
  logic [DW-1:0]     dwell_q;
  logic [N_KEYS-1:0] samp_q;
  logic              frame_end_q;
  res_e              prev_cls_q;
  logic [KEY_W-1:0]  prev_code_q;
  logic [SW-1:0]     stable_q;
  logic              acc_held_q;
  logic [KEY_W-1:0]  acc_code_q;
  logic              multi_q;
  logic              evt_valid_q;
  logic [KEY_W-1:0]  evt_code_q;
  logic              evt_press_q;

  logic [1:0]        key_cnt;
  res_e              res_cls_d;
  logic [KEY_W-1:0]  res_code_d;
  logic [SW-1:0]     stable_d;
  logic              differs;
  logic              slot_free;
  logic              accept;

  // Classify the previous frame's samples; key_cnt saturates at 2 (= more than one).
  always_comb begin
    key_cnt    = 2'd0;
    res_code_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (samp_q[k]) begin
        if (key_cnt != 2'd2) key_cnt = key_cnt + 2'd1;
        res_code_d = KEY_W'(k);
      end
    end
    res_cls_d = (key_cnt == 2'd0) ? RES_NONE : (key_cnt == 2'd1) ? RES_KEY : RES_MULTI;
    if (res_cls_d == prev_cls_q && (res_cls_d != RES_KEY || res_code_d == prev_code_q))
      stable_d = (stable_q == SW'(DEBOUNCE_FRAMES)) ? stable_q : stable_q + SW'(1);
    else
      stable_d = SW'(1);
    differs   = (res_cls_d == RES_KEY) ? (!acc_held_q || res_code_d != acc_code_q) : acc_held_q;
    slot_free = !evt_valid_q || evt_if.evt_ready;
    accept    = frame_end_q && res_cls_d != RES_MULTI && stable_d >= SW'(DEBOUNCE_FRAMES)
                && differs && slot_free;
  end

`ifdef KPD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_first_q;
  logic          evt_repeat_q;
  assign evt_if.evt_repeat = evt_repeat_q;
`else
  assign evt_if.evt_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_q     <= 1'b0;
      col_idx_q    <= '0;
      dwell_q      <= '0;
      samp_q       <= '0;
      frame_end_q  <= 1'b0;
      prev_cls_q   <= RES_NONE;
      prev_code_q  <= '0;
      stable_q     <= '0;
      acc_held_q   <= 1'b0;
      acc_code_q   <= '0;
      multi_q      <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_press_q  <= 1'b0;
`ifdef KPD_REPEAT_EN
      rpt_cnt_q    <= '0;
      rpt_first_q  <= 1'b1;
      evt_repeat_q <= 1'b0;
`endif
    end else begin
      // Scanning starts one cycle after reset so that column 0 gets a full dwell.
      active_q    <= 1'b1;
      frame_end_q <= active_q && dwell_q == DW'(COL_DWELL - 1) && col_idx_q == CW'(N_COLS - 1);
      if (active_q) begin
        if (dwell_q == DW'(COL_DWELL - 1)) begin
          dwell_q   <= '0;
          col_idx_q <= (col_idx_q == CW'(N_COLS - 1)) ? '0 : col_idx_q + CW'(1);
        end else begin
          dwell_q <= dwell_q + DW'(1);
        end
        if (dwell_q == DW'(SETTLE)) begin
          for (int r = 0; r < N_ROWS; r++)
            samp_q[r * N_COLS + int'(col_idx_q)] <= ~row_i[r];
        end
      end

      if (evt_valid_q && evt_if.evt_ready) evt_valid_q <= 1'b0;

      if (frame_end_q) begin
        prev_cls_q  <= res_cls_d;
        prev_code_q <= res_code_d;
        stable_q    <= stable_d;
        multi_q     <= (res_cls_d == RES_MULTI);
        // A key-to-key change releases first; the new press needs another qualifying frame.
        if (accept) begin
          evt_valid_q <= 1'b1;
          if (acc_held_q) begin
            evt_code_q  <= acc_code_q;
            evt_press_q <= 1'b0;
            acc_held_q  <= 1'b0;
          end else begin
            evt_code_q  <= res_code_d;
            evt_press_q <= 1'b1;
            acc_held_q  <= 1'b1;
            acc_code_q  <= res_code_d;
          end
        end
`ifdef KPD_REPEAT_EN
        if (accept) evt_repeat_q <= 1'b0;
        if (accept || res_cls_d == RES_MULTI) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
        end else if (acc_held_q) begin
          if (rpt_cnt_q + RW'(1) == (rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE))) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
            // A busy slot drops this repeat; the cadence carries on regardless.
            if (slot_free) begin
              evt_valid_q  <= 1'b1;
              evt_code_q   <= acc_code_q;
              evt_press_q  <= 1'b1;
              evt_repeat_q <= 1'b1;
            end
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RW'(1);
          end
        end
`endif
      end
    end
  end

  assign col_o            = active_q ? ~(N_COLS'(1) << col_idx_q) : '1;
  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_code  = evt_code_q;
  assign evt_if.evt_press = evt_press_q;
  assign key_held_o       = acc_held_q;
  assign multi_key_o      = multi_q;
endmodule
